// File: rtl/ksa_pkg.sv
// ksa_pkg -- shared definitions for the pipelined Kogge-Stone adder.
//   KSA_MIN_W / KSA_MAX_W : supported operand widths (power of two in between)
//   ksa_stage_t           : per-stage pipeline record {valid, c0, g, p, x}
//                           x = a ^ b_eff is kept untouched for the final sum,
//                           c0 is the effective carry-in (carry into bit 0).
//                           Vectors are sized for KSA_MAX_W; narrower adders
//                           use the low WIDTH bits and leave the rest at zero.
//   ksa_combine()         : the prefix operator {G, P} = (Gi,Pi) o (Gj,Pj)
package ksa_pkg;

  localparam int KSA_MIN_W = 8;
  localparam int KSA_MAX_W = 64;

  typedef struct packed {
    logic                 valid;
    logic                 c0;
    logic [KSA_MAX_W-1:0] g;
    logic [KSA_MAX_W-1:0] p;
    logic [KSA_MAX_W-1:0] x;
  } ksa_stage_t;

  // Prefix combine: the upper group i absorbs the lower group j.
  function automatic logic [1:0] ksa_combine(input logic gi, input logic pi,
                                             input logic gj, input logic pj);
    return {gi | (pi & gj), pi & pj};
  endfunction

endpackage

// File: rtl/ksa_prefix_cell.sv
// ksa_prefix_cell -- one Kogge-Stone prefix node (black cell).
//   gi, pi : generate/propagate of the upper (more significant) group
//   gj, pj : generate/propagate of the lower group being absorbed
//   go, po : combined group generate/propagate
module ksa_prefix_cell
  import ksa_pkg::*;
(
  input  logic gi,
  input  logic pi,
  input  logic gj,
  input  logic pj,
  output logic go,
  output logic po
);

  assign {go, po} = ksa_combine(gi, pi, gj, pj);

endmodule

// File: rtl/ksa_pipe_adder.sv
// ksa_pipe_adder -- pipelined Kogge-Stone adder/subtractor, one beat per cycle.
//   clk, rst          : clock, asynchronous active-high reset
//   in_valid/in_ready : operand handshake (in_ready is the global advance)
//   a, b, cin, sub    : operands; sub=0 -> a+b+cin, sub=1 -> a-b
//   out_valid/out_ready : result handshake
//   sum, cout, ovf    : result, unsigned carry-out, signed overflow
// Pipeline: stage 0 (g/p), LOG2W prefix levels, final sum stage,
// so latency is LOG2W + 2 cycles. Every stage holds when out_valid && !out_ready.
module ksa_pipe_adder
  import ksa_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int LOG2W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  logic                          adv;
  logic                          c0;
  logic [WIDTH-1:0]              b_eff;
  logic [WIDTH-1:0]              g0;
  logic [WIDTH-1:0]              p0;
  logic [LOG2W-1:0][WIDTH-1:0]   lvl_g;
  logic [LOG2W-1:0][WIDTH-1:0]   lvl_p;
  logic [WIDTH-1:0]              gf;
  logic [WIDTH-1:0]              carries;
  logic                          unused_stage_bits;
  ksa_stage_t                    st  [0:LOG2W];
  ksa_stage_t                    nxt [0:LOG2W];

  // Global advance: the whole pipe moves or nothing moves; never depends on in_valid.
  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;

  assign b_eff = sub ? ~b : b;
  assign c0    = sub ? 1'b1 : cin;

  // Stage-0 generate/propagate. The carry-in is folded into bit 0 as a
  // generate at position -1, so every prefix G below is a true carry-out.
  for (genvar i = 0; i < WIDTH; i++) begin : g_gp
    if (i == 0) begin : g_lsb
      assign g0[i] = (a[i] & b_eff[i]) | ((a[i] ^ b_eff[i]) & c0);
    end else begin : g_bit
      assign g0[i] = a[i] & b_eff[i];
    end
    assign p0[i] = a[i] ^ b_eff[i];
  end

  // Prefix level k combines span 2^k; the low 2^k bits are already final.
  for (genvar k = 0; k < LOG2W; k++) begin : g_lvl
    for (genvar i = 0; i < WIDTH; i++) begin : g_node
      if (i < (2 ** k)) begin : g_pass
        assign lvl_g[k][i] = st[k].g[i];
        assign lvl_p[k][i] = st[k].p[i];
      end else begin : g_cell
        ksa_prefix_cell u_cell (
          .gi (st[k].g[i]),
          .pi (st[k].p[i]),
          .gj (st[k].g[i-(2**k)]),
          .pj (st[k].p[i-(2**k)]),
          .go (lvl_g[k][i]),
          .po (lvl_p[k][i])
        );
      end
    end
  end

  // Next-state records for every stage register (unused high bits stay zero).
  always_comb begin
    for (int k = 0; k <= LOG2W; k++) begin
      nxt[k] = '0;
    end
    nxt[0].valid          = in_valid;
    nxt[0].c0             = c0;
    nxt[0].g[WIDTH-1:0]   = g0;
    nxt[0].p[WIDTH-1:0]   = p0;
    nxt[0].x[WIDTH-1:0]   = p0;
    for (int k = 0; k < LOG2W; k++) begin
      nxt[k+1].valid        = st[k].valid;
      nxt[k+1].c0           = st[k].c0;
      nxt[k+1].g[WIDTH-1:0] = lvl_g[k];
      nxt[k+1].p[WIDTH-1:0] = lvl_p[k];
      nxt[k+1].x[WIDTH-1:0] = st[k].x[WIDTH-1:0];
    end
  end

  // Carry into bit i is the group generate of bits i-1..0 (c0 for bit 0).
  assign gf      = st[LOG2W].g[WIDTH-1:0];
  assign carries = {gf[WIDTH-2:0], st[LOG2W].c0};

  // Stage registers and registered outputs; all hold while the pipe is stalled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k <= LOG2W; k++) begin
        st[k] <= '0;
      end
      out_valid <= 1'b0;
      sum       <= '0;
      cout      <= 1'b0;
      ovf       <= 1'b0;
    end else if (adv) begin
      for (int k = 0; k <= LOG2W; k++) begin
        st[k] <= nxt[k];
      end
      out_valid <= st[LOG2W].valid;
      sum       <= st[LOG2W].x[WIDTH-1:0] ^ carries;
      cout      <= gf[WIDTH-1];
      ovf       <= gf[WIDTH-2] ^ gf[WIDTH-1];
    end
  end

  // Final-level P and padding bits of the records are intentionally not consumed.
  always_comb begin
    unused_stage_bits = 1'b0;
    for (int k = 0; k <= LOG2W; k++) begin
      unused_stage_bits = unused_stage_bits ^ (^st[k]);
    end
  end

endmodule

// File: tb/tb_ksa_pipe_adder.sv
// tb_ksa_pipe_adder -- scoreboard bench for ksa_pipe_adder (WIDTH 32, plus 8 and 64 latency runs).
module tb_ksa_pipe_adder;

  localparam int W = 32;

  logic          clk;
  logic          rst;
  logic          in_valid, in_ready, cin, sub, out_valid, out_ready, cout, ovf;
  logic [W-1:0]  a, b, sum;

  logic          in_valid8, in_ready8, out_valid8, cout8, ovf8;
  logic [7:0]    a8, b8, sum8;
  logic          in_valid64, in_ready64, out_valid64, cout64, ovf64;
  logic [63:0]   a64, b64, sum64;

  int            checks;
  int            failures;
  logic [W+1:0]  exp_q [$];

  ksa_pipe_adder #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .sub(sub),
    .out_valid(out_valid), .out_ready(out_ready), .sum(sum), .cout(cout), .ovf(ovf)
  );

  ksa_pipe_adder #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .in_valid(in_valid8), .in_ready(in_ready8),
    .a(a8), .b(b8), .cin(1'b0), .sub(1'b0),
    .out_valid(out_valid8), .out_ready(1'b1), .sum(sum8), .cout(cout8), .ovf(ovf8)
  );

  ksa_pipe_adder #(.WIDTH(64)) dut64 (
    .clk(clk), .rst(rst), .in_valid(in_valid64), .in_ready(in_ready64),
    .a(a64), .b(b64), .cin(1'b0), .sub(1'b0),
    .out_valid(out_valid64), .out_ready(1'b1), .sum(sum64), .cout(cout64), .ovf(ovf64)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: {cout, ovf, sum}; overflow from operand/result signs.
  function automatic logic [W+1:0] ref_add(input logic [W-1:0] x, input logic [W-1:0] y,
                                           input logic ci, input logic sb);
    logic [W:0]   t;
    logic [W-1:0] s;
    logic         o;
    if (sb) t = {1'b0, x} + {1'b0, ~y} + {{W{1'b0}}, 1'b1};
    else    t = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, ci};
    s = t[W-1:0];
    if (sb) o = (x[W-1] != y[W-1]) && (s[W-1] != x[W-1]);
    else    o = (x[W-1] == y[W-1]) && (s[W-1] != x[W-1]);
    return {t[W], o, s};
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    #1;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%0b exp=0", out_valid); end
    checks++; if (sum !== 32'h0) begin failures++; $display("FAIL reset_sum got=%h exp=0", sum); end
    checks++; if ({cout, ovf} !== 2'b00) begin failures++; $display("FAIL reset_flags got=%b exp=00", {cout, ovf}); end
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%0b exp=1", in_ready); end
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL post_reset_in_ready got=%0b exp=1", in_ready); end
  endtask

  task automatic test_carry_chain();
    int lat;
    @(posedge clk); #1;
    out_ready = 1'b1; in_valid = 1'b1; a = 32'hFFFFFFFF; b = 32'h00000001; cin = 1'b0; sub = 1'b0;
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
      in_valid = 1'b0;
    end while (!out_valid && lat < 20);
    checks++; if (lat !== 7) begin failures++; $display("FAIL carry_latency got=%0d exp=7", lat); end
    checks++; if (sum !== 32'h0) begin failures++; $display("FAIL carry_sum got=%h exp=00000000", sum); end
    checks++; if (cout !== 1'b1) begin failures++; $display("FAIL carry_cout got=%0b exp=1", cout); end
    checks++; if (ovf !== 1'b0) begin failures++; $display("FAIL carry_ovf got=%0b exp=0", ovf); end
  endtask

  task automatic test_overflow();
    logic [W-1:0] ta [2] = '{32'h7FFFFFFF, 32'h00000005};
    logic [W-1:0] tb [2] = '{32'h00000001, 32'h00000007};
    logic         ts [2] = '{1'b0, 1'b1};
    logic [W-1:0] es [2] = '{32'h80000000, 32'hFFFFFFFE};
    logic         ec [2] = '{1'b0, 1'b0};
    logic         eo [2] = '{1'b1, 1'b0};
    int           lat;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      in_valid = 1'b1; a = ta[i]; b = tb[i]; sub = ts[i]; cin = 1'b0;
      lat = 0;
      do begin
        @(posedge clk); #1;
        lat++;
        in_valid = 1'b0;
      end while (!out_valid && lat < 20);
      checks++; if (lat !== 7) begin failures++; $display("FAIL ovf_latency[%0d] got=%0d exp=7", i, lat); end
      checks++; if (sum !== es[i]) begin failures++; $display("FAIL ovf_sum[%0d] got=%h exp=%h", i, sum, es[i]); end
      checks++; if (cout !== ec[i]) begin failures++; $display("FAIL ovf_cout[%0d] got=%0b exp=%0b", i, cout, ec[i]); end
      checks++; if (ovf !== eo[i]) begin failures++; $display("FAIL ovf_ovf[%0d] got=%0b exp=%0b", i, ovf, eo[i]); end
    end
  endtask

  task automatic test_stream();
    localparam int N = 1000;
    int sent, got, cyc, first_c, last_c;
    logic [W+1:0] e;
    exp_q.delete();
    sent = 0; got = 0; cyc = 0; first_c = -1; last_c = -1;
    @(posedge clk); #1;
    out_ready = 1'b1; in_valid = 1'b1;
    a = $urandom; b = $urandom; cin = 1'($urandom_range(0, 1)); sub = 1'($urandom_range(0, 1));
    while ((sent < N || exp_q.size() > 0) && cyc < N + 40) begin
      @(negedge clk);
      if (out_valid && out_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++; $display("FAIL stream_spurious got=%h exp=none", sum);
        end else begin
          e = exp_q.pop_front();
          if ({cout, ovf, sum} !== e) begin
            failures++; $display("FAIL stream_beat[%0d] got=%h exp=%h", got, {cout, ovf, sum}, e);
          end
        end
        if (first_c < 0) first_c = cyc;
        last_c = cyc;
        got++;
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(ref_add(a, b, cin, sub));
        sent++;
      end
      @(posedge clk); #1;
      if (sent < N) begin
        a = $urandom; b = $urandom; cin = 1'($urandom_range(0, 1)); sub = 1'($urandom_range(0, 1));
      end else begin
        in_valid = 1'b0;
      end
      cyc++;
    end
    checks++; if (got !== N) begin failures++; $display("FAIL stream_count got=%0d exp=%0d", got, N); end
    checks++; if (last_c - first_c !== N - 1) begin failures++; $display("FAIL stream_rate got=%0d exp=%0d", last_c - first_c, N - 1); end
  endtask

  task automatic test_stall();
    logic [W+1:0] held, e;
    int           n, lost;
    exp_q.delete();
    @(posedge clk); #1;
    out_ready = 1'b0; in_valid = 1'b1;
    a = $urandom; b = $urandom; cin = 1'($urandom_range(0, 1)); sub = 1'($urandom_range(0, 1));
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (in_valid && in_ready) exp_q.push_back(ref_add(a, b, cin, sub));
      if (out_valid) break;
      @(posedge clk); #1;
      a = $urandom; b = $urandom; cin = 1'($urandom_range(0, 1)); sub = 1'($urandom_range(0, 1));
    end
    checks++; if (exp_q.size() !== 7) begin failures++; $display("FAIL stall_fill got=%0d exp=7", exp_q.size()); end
    held = {cout, ovf, sum};
    lost = 0;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      a = $urandom; b = $urandom;
      @(negedge clk);
      if (in_ready !== 1'b0 || out_valid !== 1'b1 || {cout, ovf, sum} !== held) lost++;
      if (in_valid && in_ready) exp_q.push_back(ref_add(a, b, cin, sub));
    end
    checks++; if (lost !== 0) begin failures++; $display("FAIL stall_hold got=%0d bad cycles exp=0", lost); end
    @(posedge clk); #1;
    in_valid = 1'b0; out_ready = 1'b1;
    n = 0;
    for (int c = 0; c < 30 && exp_q.size() > 0; c++) begin
      @(negedge clk);
      if (out_valid && out_ready) begin
        e = exp_q.pop_front();
        checks++;
        if ({cout, ovf, sum} !== e) begin failures++; $display("FAIL stall_drain[%0d] got=%h exp=%h", n, {cout, ovf, sum}, e); end
        n++;
      end
      @(posedge clk); #1;
    end
    checks++; if (exp_q.size() !== 0) begin failures++; $display("FAIL stall_left got=%0d exp=0", exp_q.size()); end
  endtask

  task automatic test_async_reset();
    logic [W+1:0] e;
    int           stale, lat;
    @(posedge clk); #1;
    out_ready = 1'b1; in_valid = 1'b1; a = $urandom; b = $urandom; cin = 1'b0; sub = 1'b0;
    @(posedge clk); #1; in_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      a = $urandom; b = $urandom;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL areset_pre_valid got=%0b exp=1", out_valid); end
    #2;
    rst = 1'b1;
    #1;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL areset_out_valid got=%0b exp=0", out_valid); end
    checks++; if ({cout, ovf, sum} !== 34'h0) begin failures++; $display("FAIL areset_outputs got=%h exp=0", {cout, ovf, sum}); end
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL areset_in_ready got=%0b exp=1", in_ready); end
    @(posedge clk); #1;
    rst = 1'b0;
    stale = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (out_valid !== 1'b0) stale++;
    end
    checks++; if (stale !== 0) begin failures++; $display("FAIL areset_stale got=%0d exp=0", stale); end
    @(posedge clk); #1;
    in_valid = 1'b1; a = $urandom; b = $urandom; cin = 1'b1; sub = 1'b0;
    e = ref_add(a, b, cin, sub);
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
      in_valid = 1'b0;
    end while (!out_valid && lat < 20);
    checks++; if (lat !== 7) begin failures++; $display("FAIL areset_latency got=%0d exp=7", lat); end
    checks++; if ({cout, ovf, sum} !== e) begin failures++; $display("FAIL areset_result got=%h exp=%h", {cout, ovf, sum}, e); end
  endtask

  task automatic test_width_variants();
    int   lat8, lat64;
    logic d8, d64;
    logic [8:0]  r8;
    logic [64:0] r64;
    lat8 = 0; lat64 = 0; d8 = 1'b0; d64 = 1'b0; r8 = '0; r64 = '0;
    @(posedge clk); #1;
    in_valid8 = 1'b1; a8 = 8'hFF; b8 = 8'h01;
    in_valid64 = 1'b1; a64 = 64'hFFFFFFFFFFFFFFFF; b64 = 64'h1;
    for (int c = 1; c <= 20 && !(d8 && d64); c++) begin
      @(posedge clk); #1;
      in_valid8 = 1'b0; in_valid64 = 1'b0;
      if (!d8 && out_valid8) begin d8 = 1'b1; lat8 = c; r8 = {cout8, sum8}; end
      if (!d64 && out_valid64) begin d64 = 1'b1; lat64 = c; r64 = {cout64, sum64}; end
    end
    checks++; if (lat8 !== 5) begin failures++; $display("FAIL w8_latency got=%0d exp=5", lat8); end
    checks++; if (r8 !== 9'h100) begin failures++; $display("FAIL w8_result got=%h exp=100", r8); end
    checks++; if (lat64 !== 8) begin failures++; $display("FAIL w64_latency got=%0d exp=8", lat64); end
    checks++; if (r64 !== {1'b1, 64'h0}) begin failures++; $display("FAIL w64_result got=%h exp=1_0000000000000000", r64); end
  endtask

  initial begin
    checks = 0; failures = 0;
    rst = 1'b1;
    in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0; out_ready = 1'b1;
    in_valid8 = 1'b0; a8 = '0; b8 = '0;
    in_valid64 = 1'b0; a64 = '0; b64 = '0;
    repeat (2) @(posedge clk);
    test_reset();
    test_carry_chain();
    test_overflow();
    test_stream();
    test_stall();
    test_async_reset();
    test_width_variants();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
